// File: rtl/io_port_unit.sv
// Character I/O port for the basic computer: RX FIFO feeding INPR/FGI, TX handshake from OUTR/FGO.
// Optional overrun tracking enabled by defining IO_OVERRUN_EN.
module io_port_unit #(
  parameter int RX_DEPTH = 4,
  parameter int TX_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ien_in,
  input  logic       cpu_inp_clr,
  input  logic       cpu_out_ld,
  input  logic [7:0] cpu_ac_in,
  input  logic       cpu_ovr_clr,
  output logic [7:0] inpr_out,
  output logic       fgi,
  output logic       fgo,
  output logic       int_req,
  input  logic       dev_rx_valid,
  input  logic [7:0] dev_rx_data,
  output logic       dev_rx_ready,
  output logic       dev_tx_valid,
  output logic [7:0] dev_tx_data,
  input  logic       dev_tx_ready,
  output logic       ovr_flag,
  output logic [7:0] ovr_count
);

  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RECOVER
  } tx_state_t;

  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          fgi_q;
  logic [7:0]    inpr_q;
  logic [7:0]    outr_q;
  tx_state_t     state;
  tx_state_t     state_n;
  logic [GW-1:0] gap;
  logic [GW-1:0] gap_n;
  logic          outr_ld;

  // Ready comes from the registered count only, so a refill pop never
  // frees a slot for a same-cycle push.
  assign dev_rx_ready = (cnt != CW'(RX_DEPTH));
  assign push         = dev_rx_valid & dev_rx_ready;
  assign pop          = ~fgi_q & (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= dev_rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
    end else if (pop) begin
      inpr_q <= mem[rp];
      fgi_q  <= 1'b1;
    end else if (cpu_inp_clr & fgi_q) begin
      fgi_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gap    <= '0;
      outr_q <= '0;
    end else begin
      state <= state_n;
      gap   <= gap_n;
      if (outr_ld) outr_q <= cpu_ac_in;
    end
  end

  always_comb begin
    state_n = state;
    gap_n   = gap;
    outr_ld = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_out_ld) begin
          outr_ld = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (dev_tx_ready) begin
          if (TX_GAP == 0) begin
            state_n = IDLE;
          end else begin
            gap_n   = GW'(TX_GAP);
            state_n = RECOVER;
          end
        end
      end
      RECOVER: begin
        gap_n = gap - GW'(1);
        if (gap == GW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign inpr_out     = inpr_q;
  assign fgi          = fgi_q;
  assign fgo          = (state == IDLE);
  assign dev_tx_valid = (state == BUSY);
  assign dev_tx_data  = outr_q;
  assign int_req      = ien_in & (fgi_q | fgo);

`ifdef IO_OVERRUN_EN
  logic       ovr;
  logic       ovr_q;
  logic [7:0] ovr_cnt_q;

  assign ovr = dev_rx_valid & ~dev_rx_ready;

  // A clear coinciding with an overrun restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else if (cpu_ovr_clr) begin
      ovr_q     <= ovr;
      ovr_cnt_q <= {7'd0, ovr};
    end else if (ovr) begin
      ovr_q <= 1'b1;
      if (ovr_cnt_q != 8'hff) ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign ovr_flag  = ovr_q;
  assign ovr_count = ovr_cnt_q;
`else
  logic unused_ovr_clr;

  assign unused_ovr_clr = cpu_ovr_clr;
  assign ovr_flag       = 1'b0;
  assign ovr_count      = 8'd0;
`endif

endmodule

// File: tb/tb_io_port_unit.sv
// Bench for io_port_unit: per-cycle RX vector table, RX/TX scoreboards,
// hand sequences for transmit timing, overrun and mid-operation reset.
module tb_io_port_unit;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ien_in;
  logic       cpu_inp_clr;
  logic       cpu_out_ld;
  logic [7:0] cpu_ac_in;
  logic       cpu_ovr_clr;
  logic [7:0] inpr_out;
  logic       fgi;
  logic       fgo;
  logic       int_req;
  logic       dev_rx_valid;
  logic [7:0] dev_rx_data;
  logic       dev_rx_ready;
  logic       dev_tx_valid;
  logic [7:0] dev_tx_data;
  logic       dev_tx_ready;
  logic       ovr_flag;
  logic [7:0] ovr_count;

  always #5 clk = ~clk;

  io_port_unit #(
    .RX_DEPTH(DEPTH),
    .TX_GAP  (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ien_in      (ien_in),
    .cpu_inp_clr (cpu_inp_clr),
    .cpu_out_ld  (cpu_out_ld),
    .cpu_ac_in   (cpu_ac_in),
    .cpu_ovr_clr (cpu_ovr_clr),
    .inpr_out    (inpr_out),
    .fgi         (fgi),
    .fgo         (fgo),
    .int_req     (int_req),
    .dev_rx_valid(dev_rx_valid),
    .dev_rx_data (dev_rx_data),
    .dev_rx_ready(dev_rx_ready),
    .dev_tx_valid(dev_tx_valid),
    .dev_tx_data (dev_tx_data),
    .dev_tx_ready(dev_tx_ready),
    .ovr_flag    (ovr_flag),
    .ovr_count   (ovr_count)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       clr;
    logic       acc;
    logic       efgi;
    logic       erdy;
    logic [7:0] einpr;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic       fgi_prev = 1'b0;
  vec_t       tbl[17];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: INPR checked on each fgi rise, OUTR on each accept.
  always @(negedge clk) begin
    if (!rst && fgi && !fgi_prev) begin
      if (rxq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got %0h want none", inpr_out);
      end else begin
        chk("rx_char", {24'd0, inpr_out}, {24'd0, rxq.pop_front()});
      end
    end
    fgi_prev = fgi;
    if (!rst && dev_tx_valid && dev_tx_ready) begin
      if (txq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected: got %0h want none", dev_tx_data);
      end else begin
        chk("tx_char", {24'd0, dev_tx_data}, {24'd0, txq.pop_front()});
      end
    end
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41};
    tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10};
    tbl[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10};
    tbl[3]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10};
    tbl[4]  = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10};
    tbl[7]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h13};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h14};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h14};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h14};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h14};

    rst          = 1'b1;
    ien_in       = 1'b1;
    cpu_inp_clr  = 1'b0;
    cpu_out_ld   = 1'b0;
    cpu_ac_in    = 8'h00;
    cpu_ovr_clr  = 1'b0;
    dev_rx_valid = 1'b0;
    dev_rx_data  = 8'h00;
    dev_tx_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_fgo", {31'd0, fgo}, 32'd1);
    chk("rst_fgi", {31'd0, fgi}, 32'd0);
    chk("rst_inpr", {24'd0, inpr_out}, 32'h00);
    chk("rst_txv", {31'd0, dev_tx_valid}, 32'd0);
    chk("rst_rxrdy", {31'd0, dev_rx_ready}, 32'd1);
    chk("rst_intreq", {31'd0, int_req}, 32'd1);
    chk("rst_ovrf", {31'd0, ovr_flag}, 32'd0);
    chk("rst_ovrc", {24'd0, ovr_count}, 32'd0);
    ien_in = 1'b0;
    #1;
    chk("ien0_intreq", {31'd0, int_req}, 32'd0);
    ien_in = 1'b1;

    dev_rx_valid = 1'b1;
    dev_rx_data  = 8'h41;
    rxq.push_back(8'h41);
    step();
    dev_rx_valid = 1'b0;
    chk("lat_fgi_n", {31'd0, fgi}, 32'd0);
    step();
    chk("lat_fgi_n1", {31'd0, fgi}, 32'd1);
    chk("lat_inpr", {24'd0, inpr_out}, 32'h41);
    cpu_inp_clr = 1'b1;
    step();
    cpu_inp_clr = 1'b0;
    chk("clr_fgi", {31'd0, fgi}, 32'd0);
    chk("clr_inpr", {24'd0, inpr_out}, 32'h41);
    step();
    chk("clr_fgi_hold", {31'd0, fgi}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      dev_rx_valid = tbl[i].v;
      dev_rx_data  = tbl[i].d;
      cpu_inp_clr  = tbl[i].clr;
      if (tbl[i].v)
        chk($sformatf("vec%0d_rdy_pre", i), {31'd0, dev_rx_ready},
            {31'd0, tbl[i].acc});
      if (tbl[i].acc) rxq.push_back(tbl[i].d);
      step();
      chk($sformatf("vec%0d_fgi", i), {31'd0, fgi}, {31'd0, tbl[i].efgi});
      chk($sformatf("vec%0d_rdy", i), {31'd0, dev_rx_ready},
          {31'd0, tbl[i].erdy});
      chk($sformatf("vec%0d_inpr", i), {24'd0, inpr_out},
          {24'd0, tbl[i].einpr});
    end
    dev_rx_valid = 1'b0;
    cpu_inp_clr  = 1'b0;

    cpu_ovr_clr = 1'b1;
    step();
    cpu_ovr_clr = 1'b0;
    chk("ovr_clr_flag", {31'd0, ovr_flag}, 32'd0);
    chk("ovr_clr_cnt", {24'd0, ovr_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      dev_rx_valid = 1'b1;
      dev_rx_data  = 8'h20 + 8'(i);
      rxq.push_back(dev_rx_data);
      step();
    end
    chk("full_rdy", {31'd0, dev_rx_ready}, 32'd0);
    dev_rx_data = 8'hee;
    step();
    step();
    step();
`ifdef IO_OVERRUN_EN
    chk("ovr3_flag", {31'd0, ovr_flag}, 32'd1);
    chk("ovr3_cnt", {24'd0, ovr_count}, 32'd3);
`else
    chk("ovr3_flag", {31'd0, ovr_flag}, 32'd0);
    chk("ovr3_cnt", {24'd0, ovr_count}, 32'd0);
`endif
    cpu_ovr_clr = 1'b1;
    step();
    cpu_ovr_clr  = 1'b0;
    dev_rx_valid = 1'b0;
`ifdef IO_OVERRUN_EN
    chk("ovr_clr4_flag", {31'd0, ovr_flag}, 32'd1);
    chk("ovr_clr4_cnt", {24'd0, ovr_count}, 32'd1);
`else
    chk("ovr_clr4_flag", {31'd0, ovr_flag}, 32'd0);
    chk("ovr_clr4_cnt", {24'd0, ovr_count}, 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      cpu_inp_clr = 1'b1;
      step();
      cpu_inp_clr = 1'b0;
      step();
    end
    chk("drain_fgi", {31'd0, fgi}, 32'd0);
    chk("drain_rdy", {31'd0, dev_rx_ready}, 32'd1);
    chk("drain_rxq", rxq.size(), 32'd0);

    cpu_out_ld = 1'b1;
    cpu_ac_in  = 8'h5a;
    txq.push_back(8'h5a);
    step();
    cpu_out_ld = 1'b0;
    chk("tx_fgo_ld", {31'd0, fgo}, 32'd0);
    chk("tx_busy_int", {31'd0, int_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx_valid%0d", i), {31'd0, dev_tx_valid}, 32'd1);
      chk($sformatf("tx_data%0d", i), {24'd0, dev_tx_data}, 32'h5a);
      if (i == 0) begin
        cpu_out_ld = 1'b1;
        cpu_ac_in  = 8'h33;
      end
      step();
      cpu_out_ld = 1'b0;
    end
    chk("tx_valid3", {31'd0, dev_tx_valid}, 32'd1);
    chk("tx_data3", {24'd0, dev_tx_data}, 32'h5a);
    dev_tx_ready = 1'b1;
    step();
    dev_tx_ready = 1'b0;
    chk("tx_acc_valid", {31'd0, dev_tx_valid}, 32'd0);
    chk("tx_gap0_fgo", {31'd0, fgo}, 32'd0);
    step();
    chk("tx_gap1_fgo", {31'd0, fgo}, 32'd0);
    step();
    chk("tx_gap2_fgo", {31'd0, fgo}, 32'd1);
    chk("tx_outr_kept", {24'd0, dev_tx_data}, 32'h5a);

    cpu_out_ld   = 1'b1;
    cpu_ac_in    = 8'hc3;
    dev_tx_ready = 1'b1;
    txq.push_back(8'hc3);
    step();
    cpu_out_ld = 1'b0;
    chk("tx2_valid", {31'd0, dev_tx_valid}, 32'd1);
    chk("tx2_data", {24'd0, dev_tx_data}, 32'hc3);
    step();
    dev_tx_ready = 1'b0;
    chk("tx2_done", {31'd0, dev_tx_valid}, 32'd0);
    step();
    step();
    chk("tx2_fgo", {31'd0, fgo}, 32'd1);

    cpu_out_ld = 1'b1;
    cpu_ac_in  = 8'h9c;
    step();
    cpu_out_ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dev_rx_valid = 1'b1;
      dev_rx_data  = 8'h60 + 8'(i);
      rxq.push_back(dev_rx_data);
      step();
    end
    dev_rx_valid = 1'b0;
    chk("pre_rst_txv", {31'd0, dev_tx_valid}, 32'd1);
    chk("pre_rst_fgi", {31'd0, fgi}, 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_txv", {31'd0, dev_tx_valid}, 32'd0);
    chk("mid_rst_fgo", {31'd0, fgo}, 32'd1);
    chk("mid_rst_fgi", {31'd0, fgi}, 32'd0);
    chk("mid_rst_inpr", {24'd0, inpr_out}, 32'h00);
    chk("mid_rst_rdy", {31'd0, dev_rx_ready}, 32'd1);
    rxq.delete();
    rst = 1'b0;
    step();
    step();
    step();
    chk("post_rst_fgi", {31'd0, fgi}, 32'd0);
    chk("post_rst_txv", {31'd0, dev_tx_valid}, 32'd0);
    chk("end_rxq", rxq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
